// File: rtl/trace_slot_serializer_if.sv
// rtl/trace_slot_serializer_if.sv - trace packet type and serializer port bundle
// master = serializer side, slave = core/sink side.
package trace_slot_serializer_pkg;
  typedef struct packed {
    logic [95:0] trace_rv_i_insn_ip;
    logic [95:0] trace_rv_i_address_ip;
    logic [2:0]  trace_rv_i_valid_ip;
    logic [2:0]  trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic [2:0]  trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } trace_pkt_t;
endpackage

interface trace_slot_serializer_if;
  import trace_slot_serializer_pkg::*;

  trace_pkt_t  trace_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_slot;
  logic [31:0] out_insn;
  logic [31:0] out_addr;
  logic        out_exc;
  logic        out_int;
  logic [4:0]  out_ecause;
  logic [31:0] out_tval;
  logic        out_last;
  logic [15:0] drop_cnt;
  logic        fifo_empty;

  modport master (
    input  trace_in, out_ready,
    output out_valid, out_slot, out_insn, out_addr, out_exc, out_int,
           out_ecause, out_tval, out_last, drop_cnt, fifo_empty
  );

  modport slave (
    output trace_in, out_ready,
    input  out_valid, out_slot, out_insn, out_addr, out_exc, out_int,
           out_ecause, out_tval, out_last, drop_cnt, fifo_empty
  );
endinterface

// File: rtl/trace_slot_serializer.sv
// rtl/trace_slot_serializer.sv - buffers per-cycle trace packets, emits one slot record per handshake
// Optional feature macro RV_TRACE_TVAL_EN: keep per-entry tval; otherwise out_tval is 32'h0.
module trace_slot_serializer
  import trace_slot_serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_l,
  trace_slot_serializer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    valid_q  [DEPTH];
  logic [95:0]   insn_q   [DEPTH];
  logic [95:0]   addr_q   [DEPTH];
  logic [2:0]    exc_q    [DEPTH];
  logic [2:0]    intr_q   [DEPTH];
  logic [4:0]    ecause_q [DEPTH];
`ifdef RV_TRACE_TVAL_EN
  logic [31:0]   tval_q   [DEPTH];
`else
  logic          unused_tval;
  assign unused_tval = ^bus.trace_in.trace_rv_i_tval_ip;
`endif

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    slot_q, slot_d;
  logic [15:0]   drop_q, drop_d;

  logic          empty, full, in_any, handshake, pop, push, drop;
  logic [2:0]    pending, rest;
  logic [1:0]    cur_slot, nxt_slot;
  logic          is_last;
  logic          hd_exc, hd_int;

  function automatic logic [31:0] lane(input logic [95:0] v, input logic [1:0] s);
    case (s)
      2'd0:    lane = v[31:0];
      2'd1:    lane = v[63:32];
      default: lane = v[95:64];
    endcase
  endfunction

  // Cursor logic: current record is the lowest valid slot at or above slot_q.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    pending   = valid_q[rd_ptr_q] & (3'b111 << slot_q);
    cur_slot  = pending[0] ? 2'd0 : (pending[1] ? 2'd1 : 2'd2);
    rest      = pending & ~(3'b001 << cur_slot);
    is_last   = (rest == 3'b000);
    nxt_slot  = rest[1] ? 2'd1 : 2'd2;
    in_any    = |bus.trace_in.trace_rv_i_valid_ip;
    handshake = !empty && bus.out_ready;
    pop       = handshake && is_last;
    push      = in_any && (!full || pop);
    drop      = in_any && full && !pop;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    slot_d   = slot_q;
    if (handshake) begin
      slot_d = is_last ? 2'd0 : nxt_slot;
    end
    drop_d = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      slot_q   <= '0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= '0;
        insn_q[i]   <= '0;
        addr_q[i]   <= '0;
        exc_q[i]    <= '0;
        intr_q[i]   <= '0;
        ecause_q[i] <= '0;
`ifdef RV_TRACE_TVAL_EN
        tval_q[i]   <= '0;
`endif
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      slot_q   <= slot_d;
      drop_q   <= drop_d;
      // A full FIFO may overwrite the head entry only when it pops this same edge.
      if (push) begin
        valid_q[wr_ptr_q]  <= bus.trace_in.trace_rv_i_valid_ip;
        insn_q[wr_ptr_q]   <= bus.trace_in.trace_rv_i_insn_ip;
        addr_q[wr_ptr_q]   <= bus.trace_in.trace_rv_i_address_ip;
        exc_q[wr_ptr_q]    <= bus.trace_in.trace_rv_i_exception_ip;
        intr_q[wr_ptr_q]   <= bus.trace_in.trace_rv_i_interrupt_ip;
        ecause_q[wr_ptr_q] <= bus.trace_in.trace_rv_i_ecause_ip;
`ifdef RV_TRACE_TVAL_EN
        tval_q[wr_ptr_q]   <= bus.trace_in.trace_rv_i_tval_ip;
`endif
      end
    end
  end

  always_comb begin
    hd_exc         = exc_q[rd_ptr_q][cur_slot];
    hd_int         = intr_q[rd_ptr_q][cur_slot];
    bus.out_valid  = !empty;
    bus.fifo_empty = empty;
    bus.drop_cnt   = drop_q;
    bus.out_slot   = '0;
    bus.out_insn   = '0;
    bus.out_addr   = '0;
    bus.out_exc    = 1'b0;
    bus.out_int    = 1'b0;
    bus.out_ecause = '0;
    bus.out_tval   = '0;
    bus.out_last   = 1'b0;
    if (!empty) begin
      bus.out_slot   = cur_slot;
      bus.out_insn   = lane(insn_q[rd_ptr_q], cur_slot);
      bus.out_addr   = lane(addr_q[rd_ptr_q], cur_slot);
      bus.out_exc    = hd_exc;
      bus.out_int    = hd_int;
      bus.out_ecause = (hd_exc || hd_int) ? ecause_q[rd_ptr_q] : 5'd0;
`ifdef RV_TRACE_TVAL_EN
      bus.out_tval   = hd_exc ? tval_q[rd_ptr_q] : 32'h0;
`endif
      bus.out_last   = is_last;
    end
  end
endmodule
